// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared control-bundle types and constants for the ID..WB control pipe
package ctrl_pkg;

  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] R_type = 7'b0110011;
  localparam logic [6:0] BEQ    = 7'b1100011;
  localparam logic [6:0] ADDI   = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] ALUOp;
    logic       ALUSrc;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall and taken-branch flush detection
module hazard_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_branch,
  input  logic                  ex_mem_read,
  input  logic                  ex_zero,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  output logic                  taken,
  output logic                  stall,
  output logic                  flush_ifid
);

  logic rs_match;

  assign taken      = ex_valid & ex_branch & ex_zero;
  assign rs_match   = (ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2));
  // A taken branch discards the ID instruction, so there is nothing left to stall for.
  assign stall      = ~taken & ex_valid & ex_mem_read & (ex_rd != '0) & id_valid & rs_match;
  assign flush_ifid = taken;

endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - ID/EX, EX/MEM, MEM/WB control registers with hazard handling and event counters
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [1:0]            id_ALUOp,
  input  logic                  id_ALUSrc,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic                  ex_zero,
  output logic [1:0]            ex_ALUOp,
  output logic                  ex_ALUSrc,
  output logic                  ex_branch,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  stall,
  output logic                  flush_ifid,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  ctrl_bundle_t          idex_ctrl_d, idex_ctrl_q;
  logic                  idex_valid_d, idex_valid_q;
  logic [REG_ADDR_W-1:0] idex_rd_d, idex_rd_q;

  logic                  exmem_valid_q, exmem_mem_read_q, exmem_mem_write_q;
  logic                  exmem_reg_write_q, exmem_mem_to_reg_q;
  logic [REG_ADDR_W-1:0] exmem_rd_q;

  logic                  memwb_valid_q, memwb_reg_write_q, memwb_mem_to_reg_q;
  logic [REG_ADDR_W-1:0] memwb_rd_q;

  logic [CNT_W-1:0]      stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  logic                  taken;

  hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .ex_valid    (idex_valid_q),
    .ex_branch   (idex_ctrl_q.branch),
    .ex_mem_read (idex_ctrl_q.mem_read),
    .ex_zero     (ex_zero),
    .ex_rd       (idex_rd_q),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .taken       (taken),
    .stall       (stall),
    .flush_ifid  (flush_ifid)
  );

  always_comb begin
    idex_valid_d = 1'b0;
    idex_ctrl_d  = CTRL_BUBBLE;
    idex_rd_d    = '0;
    if (id_valid && !stall && !taken) begin
      idex_valid_d = 1'b1;
      idex_rd_d    = id_rd;
      // Stores and branches leave mem_to_reg undefined; pin it so WB never sees junk.
      idex_ctrl_d  = '{ALUOp: id_ALUOp, ALUSrc: id_ALUSrc, branch: id_branch,
                       mem_read: id_mem_read, mem_write: id_mem_write,
                       reg_write: id_reg_write, mem_to_reg: id_mem_to_reg & id_reg_write};
    end
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid_q       <= 1'b0;
      idex_ctrl_q        <= CTRL_BUBBLE;
      idex_rd_q          <= '0;
      exmem_valid_q      <= 1'b0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_rd_q         <= '0;
      memwb_valid_q      <= 1'b0;
      memwb_reg_write_q  <= 1'b0;
      memwb_mem_to_reg_q <= 1'b0;
      memwb_rd_q         <= '0;
      stall_cnt_q        <= '0;
      flush_cnt_q        <= '0;
    end else begin
      idex_valid_q       <= idex_valid_d;
      idex_ctrl_q        <= idex_ctrl_d;
      idex_rd_q          <= idex_rd_d;
      exmem_valid_q      <= idex_valid_q;
      exmem_mem_read_q   <= idex_ctrl_q.mem_read;
      exmem_mem_write_q  <= idex_ctrl_q.mem_write;
      exmem_reg_write_q  <= idex_ctrl_q.reg_write;
      exmem_mem_to_reg_q <= idex_ctrl_q.mem_to_reg;
      exmem_rd_q         <= idex_rd_q;
      memwb_valid_q      <= exmem_valid_q;
      memwb_reg_write_q  <= exmem_reg_write_q;
      memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      memwb_rd_q         <= exmem_rd_q;
      stall_cnt_q        <= stall_cnt_d;
      flush_cnt_q        <= flush_cnt_d;
    end
  end

  assign ex_ALUOp      = idex_ctrl_q.ALUOp & {2{idex_valid_q}};
  assign ex_ALUSrc     = idex_ctrl_q.ALUSrc & idex_valid_q;
  assign ex_branch     = idex_ctrl_q.branch & idex_valid_q;
  assign ex_rd         = idex_rd_q & {REG_ADDR_W{idex_valid_q}};
  assign mem_mem_read  = exmem_mem_read_q & exmem_valid_q;
  assign mem_mem_write = exmem_mem_write_q & exmem_valid_q;
  assign mem_rd        = exmem_rd_q & {REG_ADDR_W{exmem_valid_q}};
  assign wb_reg_write  = memwb_reg_write_q & memwb_valid_q;
  assign wb_mem_to_reg = memwb_mem_to_reg_q & memwb_valid_q;
  assign wb_rd         = memwb_rd_q & {REG_ADDR_W{memwb_valid_q}};
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - directed bench with history-based reference model for ctrl_pipeline
module tb_ctrl_pipeline;

  localparam int AW = 5;
  localparam int CW = 2;
  localparam int CNT_MAX = 3;

  logic clk, rst_n;
  logic id_valid, id_ALUSrc, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic [1:0] id_ALUOp;
  logic [AW-1:0] id_rd, id_rs1, id_rs2;
  logic id_uses_rs2, ex_zero;
  logic [1:0] ex_ALUOp;
  logic ex_ALUSrc, ex_branch, mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic stall, flush_ifid;
  logic [CW-1:0] stall_cnt, flush_cnt;

  ctrl_pipeline #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ALUOp(id_ALUOp),
    .id_ALUSrc(id_ALUSrc), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_zero(ex_zero), .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_branch(ex_branch),
    .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .stall(stall), .flush_ifid(flush_ifid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
  endtask

  // Model: what entered EX on each of the last three cycles (index 0 = now in EX).
  typedef struct packed {
    logic v; logic [1:0] aluop; logic alusrc, br, mr, mw, rw, m2r; logic [AW-1:0] rd;
  } slot_t;
  slot_t h [3];
  int m_scnt, m_fcnt;

  always @(negedge clk) begin
    logic m_taken, m_stall;
    slot_t nx;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) h[i] = '0;
      m_scnt = 0;
      m_fcnt = 0;
      chk("rst_outs", 32'({ex_ALUOp, ex_ALUSrc, ex_branch, ex_rd, mem_mem_read, mem_mem_write,
                           mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd}), 32'd0);
      chk("rst_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
    end else begin
      m_taken = h[0].v && h[0].br && ex_zero;
      m_stall = !m_taken && h[0].v && h[0].mr && h[0].rd != 0 && id_valid &&
                (h[0].rd == id_rs1 || (id_uses_rs2 && h[0].rd == id_rs2));
      chk("m_ex_ALUOp", 32'(ex_ALUOp), 32'(h[0].aluop));
      chk("m_ex_ALUSrc", 32'(ex_ALUSrc), 32'(h[0].alusrc));
      chk("m_ex_branch", 32'(ex_branch), 32'(h[0].br));
      chk("m_ex_rd", 32'(ex_rd), 32'(h[0].rd));
      chk("m_mem_read", 32'(mem_mem_read), 32'(h[1].mr));
      chk("m_mem_write", 32'(mem_mem_write), 32'(h[1].mw));
      chk("m_mem_rd", 32'(mem_rd), 32'(h[1].rd));
      chk("m_wb_reg_write", 32'(wb_reg_write), 32'(h[2].rw));
      chk("m_wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(h[2].m2r));
      chk("m_wb_rd", 32'(wb_rd), 32'(h[2].rd));
      chk("m_stall", 32'(stall), 32'(m_stall));
      chk("m_flush", 32'(flush_ifid), 32'(m_taken));
      chk("m_stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      chk("m_flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
      if (m_stall && m_scnt < CNT_MAX) m_scnt++;
      if (m_taken && m_fcnt < CNT_MAX) m_fcnt++;
      nx = '0;
      if (id_valid && !m_stall && !m_taken)
        nx = '{v: 1'b1, aluop: id_ALUOp, alusrc: id_ALUSrc, br: id_branch, mr: id_mem_read,
               mw: id_mem_write, rw: id_reg_write, m2r: id_reg_write ? id_mem_to_reg : 1'b0,
               rd: id_rd};
      h[2] = h[1];
      h[1] = h[0];
      h[0] = nx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [1:0] op, input logic src, br, mr, mw, rw, m2r,
                        input logic [AW-1:0] rd, rs1, rs2, input logic u2);
    id_valid = 1'b1; id_ALUOp = op; id_ALUSrc = src; id_branch = br; id_mem_read = mr;
    id_mem_write = mw; id_reg_write = rw; id_mem_to_reg = m2r;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_ALUOp = 2'b00; id_ALUSrc = 1'b0; id_branch = 1'b0; id_mem_read = 1'b0;
    id_mem_write = 1'b0; id_reg_write = 1'b0; id_mem_to_reg = 1'b0;
    id_rd = '0; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    ex_zero = 1'b0;
    idle();
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("idle_stall_flush", 32'({stall, flush_ifid}), 32'd0);
    chk("idle_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);

    // R-type, rd=5
    tick();
    set_id(2'b10, 0, 0, 0, 0, 1, 0, 5'd5, 5'd1, 5'd2, 1);
    tick(); idle();
    @(negedge clk);
    chk("r_ex_ALUOp", 32'(ex_ALUOp), 32'd2);
    chk("r_ex_rd", 32'(ex_rd), 32'd5);
    tick(); @(negedge clk);
    chk("r_mem_rd", 32'(mem_rd), 32'd5);
    chk("r_mem_read", 32'(mem_mem_read), 32'd0);
    tick(); @(negedge clk);
    chk("r_wb", 32'({wb_reg_write, wb_mem_to_reg, wb_rd}), 32'({1'b1, 1'b0, 5'd5}));
    tick();

    // Load-use: LW rd=3 then ADD rs1=3
    set_id(2'b00, 1, 0, 1, 0, 1, 1, 5'd3, 5'd1, 5'd0, 0);
    tick();
    set_id(2'b10, 0, 0, 0, 0, 1, 0, 5'd4, 5'd3, 5'd2, 1);
    @(negedge clk);
    chk("lu_stall", 32'(stall), 32'd1);
    tick(); @(negedge clk);
    chk("lu_bubble_ex", 32'({ex_ALUOp, ex_ALUSrc, ex_branch, ex_rd}), 32'd0);
    chk("lu_no_2nd_stall", 32'(stall), 32'd0);
    tick(); idle(); @(negedge clk);
    chk("lu_add_late", 32'(ex_rd), 32'd4);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    repeat (3) tick();

    // Load-use with rd=0 never stalls
    set_id(2'b00, 1, 0, 1, 0, 1, 1, 5'd0, 5'd1, 5'd0, 0);
    tick();
    set_id(2'b10, 0, 0, 0, 0, 1, 0, 5'd4, 5'd0, 5'd0, 1);
    @(negedge clk);
    chk("lu_rd0_stall", 32'(stall), 32'd0);
    tick(); idle(); repeat (3) tick();

    // Taken branch with LW rd=3 in ID, then ADD rs1=3
    set_id(2'b01, 0, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1);
    tick();
    ex_zero = 1'b1;
    set_id(2'b00, 1, 0, 1, 0, 1, 1, 5'd3, 5'd1, 5'd0, 0);
    @(negedge clk);
    chk("br_flush", 32'(flush_ifid), 32'd1);
    chk("br_stall", 32'(stall), 32'd0);
    tick();
    ex_zero = 1'b0;
    set_id(2'b10, 0, 0, 0, 0, 1, 0, 5'd4, 5'd3, 5'd2, 1);
    @(negedge clk);
    chk("br_bubble_ex", 32'({ex_ALUOp, ex_ALUSrc, ex_branch, ex_rd}), 32'd0);
    chk("br_add_no_stall", 32'(stall), 32'd0);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_in_mem", 32'({mem_mem_read, mem_mem_write}), 32'd0);
    tick(); idle(); repeat (3) tick();

    // Not-taken branch
    set_id(2'b01, 0, 1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1);
    tick(); idle();
    @(negedge clk);
    chk("nt_flush", 32'(flush_ifid), 32'd0);
    repeat (3) tick();

    // Taken overrides a simultaneous load-use condition
    set_id(2'b01, 0, 1, 1, 0, 1, 0, 5'd3, 5'd1, 5'd2, 1);
    tick();
    ex_zero = 1'b1;
    set_id(2'b10, 0, 0, 0, 0, 1, 0, 5'd4, 5'd3, 5'd2, 1);
    @(negedge clk);
    chk("prio_stall", 32'(stall), 32'd0);
    chk("prio_flush", 32'(flush_ifid), 32'd1);
    tick(); ex_zero = 1'b0; idle(); repeat (3) tick();

    // SW sanitising: mem_to_reg driven high with reg_write low
    set_id(2'b00, 1, 0, 0, 1, 0, 1, 5'd7, 5'd1, 5'd2, 1);
    tick(); idle(); tick();
    @(negedge clk);
    chk("sw_mem_write", 32'(mem_mem_write), 32'd1);
    tick(); @(negedge clk);
    chk("sw_wb_m2r", 32'(wb_mem_to_reg), 32'd0);
    repeat (2) tick();

    // Five more stalls saturate the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      set_id(2'b00, 1, 0, 1, 0, 1, 1, 5'd3, 5'd1, 5'd0, 0);
      tick();
      set_id(2'b10, 0, 0, 0, 0, 1, 0, 5'd4, 5'd6, 5'd3, 1);
      repeat (2) tick();
      idle(); tick();
    end
    @(negedge clk);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd3);

    // Asynchronous reset with work in flight
    tick();
    set_id(2'b10, 0, 0, 0, 0, 1, 0, 5'd9, 5'd1, 5'd2, 1);
    tick();
    set_id(2'b00, 1, 0, 1, 0, 1, 1, 5'd10, 5'd1, 5'd0, 0);
    tick(); idle();
    #1 rst_n = 1'b0;
    #1;
    chk("async_outs", 32'({ex_ALUOp, ex_ALUSrc, ex_branch, ex_rd, mem_mem_read, mem_mem_write,
                           mem_rd, wb_reg_write, wb_mem_to_reg, wb_rd}), 32'd0);
    chk("async_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Consumer end of the ID-stage control decoder.
- Accepts the decoded control bundle for the instruction in ID and carries it through the ID/EX, EX/MEM and MEM/WB registers, presenting each stage's control signals.
- Owns load-use stall detection and taken-branch flush, and drives bubbles into the pipe.
- Sits between the decoder and the EX/MEM/WB datapath.
- Keeps saturating stall/flush event counters for debug.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_ALUOp  in  2  from decoder.
- id_ALUSrc, id_branch, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  from decoder.
- id_rd, id_rs1, id_rs2  in  REG_ADDR_W  register indices of the ID instruction.
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, SW, BEQ).
- ex_zero  in  1  ALU zero flag for the instruction in EX.
- ex_ALUOp  out  2  EX control.
- ex_ALUSrc, ex_branch  out  1  EX control.
- ex_rd  out  REG_ADDR_W  EX destination.
- mem_mem_read, mem_mem_write  out  1  MEM control.
- mem_rd  out  REG_ADDR_W  MEM destination.
- wb_reg_write, wb_mem_to_reg  out  1  WB control.
- wb_rd  out  REG_ADDR_W  WB destination.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- flush_ifid  out  1  squash IF/ID this cycle (combinational).
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage registers, valid bits, rd fields and counters clear to 0.
  - All control outputs are 0, so the pipe holds bubbles.
  - Release is synchronous to the next rising clk.
- Each stage holds a valid bit plus its remaining control fields.
  - ID/EX holds the full bundle plus rd.
  - EX/MEM holds mem_read, mem_write, reg_write, mem_to_reg and rd.
  - MEM/WB holds reg_write, mem_to_reg and rd.
- Output gating: every control output is its stored field ANDed with that stage's valid bit, so invalid stages drive 0.
- Capture sanitising: on capture into ID/EX, mem_to_reg is forced to 0 when id_reg_write=0. Unknown decoder values for SW/BEQ therefore never enter the pipe.
- Latency: a bundle presented in ID appears
  - on ex_* 1 cycle later,
  - on mem_* 2 cycles later,
  - on wb_* 3 cycles later.
- Branch taken: taken = ID/EX valid & ex_branch & ex_zero.
  - When taken, flush_ifid=1 and the next ID/EX load is a bubble (valid=0, fields 0).
  - The branch itself still advances to MEM.
- Load-use stall: stall = ID/EX valid & ex-stage mem_read & ex_rd≠0 & id_valid & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2)).
  - When stalling, ID/EX loads a bubble.
  - The upstream stages hold, so the same ID bundle is re-presented next cycle.
- Priority: taken branch overrides stall. stall is forced 0 when taken, because the ID instruction is discarded.
- id_valid=0: ID/EX loads a bubble. No stall is possible.
- Back-to-back behaviour: EX/MEM and MEM/WB always advance; the block has no downstream backpressure. Consecutive stalls are impossible, because the bubble clears the EX mem_read condition.
- Counters:
  - stall_cnt increments by 1 on each cycle with stall=1.
  - flush_cnt increments by 1 on each cycle with taken=1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-operation: all in-flight bundles are discarded immediately, and outputs drop to 0 asynchronously.

Decomposition:
- Shared package ctrl_pkg:
  - opcode constants LW, SW, R_type, BEQ, ADDI;
  - ALUOp encodings (2'b00 add, 2'b01 sub/branch, 2'b10 funct-decoded);
  - packed struct ctrl_bundle_t {ALUOp, ALUSrc, branch, mem_read, mem_write, reg_write, mem_to_reg};
  - constant CTRL_BUBBLE = all zeros.
- One sub-module: hazard_unit, combinational. It computes stall, taken and flush_ifid from the ID/EX state and the ID inputs.
- Registers and counters stay in ctrl_pipeline.

Test Plan:
- Reset then idle: hold rst_n=0 3 cycles, then release with id_valid=0 for 5 cycles -> all outputs 0; stall, flush_ifid and counters stay 0.
- Single R-type:
  - Stimulus: id_valid=1, ALUOp=10, reg_write=1, rd=5 for 1 cycle.
  - Cycle+1: ex_ALUOp=10, ex_rd=5.
  - Cycle+2: mem_rd=5, mem_mem_read=0.
  - Cycle+3: wb_reg_write=1, wb_rd=5, wb_mem_to_reg=0.
- Load-use:
  - Stimulus: LW rd=3 followed by ADD rs1=3.
  - Required: stall=1 for exactly one cycle; ex_* all 0 the next cycle; ADD enters EX one cycle late; stall_cnt=1.
  - Repeat with rd=0 -> no stall.
- Taken branch:
  - Stimulus: BEQ in EX with ex_zero=1, a LW (rd=3) in ID, and an ADD with rs1=3 next.
  - Required: flush_ifid=1, stall=0, ID/EX becomes bubble, flush_cnt=1, BEQ reaches MEM with mem controls 0. With ex_zero=0, no flush.
- SW sanitising:
  - Stimulus: id_mem_write=1, id_reg_write=0, id_mem_to_reg=x.
  - Required: wb_mem_to_reg=0 (not x) and mem_mem_write=1 at cycle+2.
- Counter saturation and async reset:
  - With CNT_W=2, force 5 stalls -> stall_cnt=3.
  - Assert rst_n low between clock edges -> all outputs 0 before the next edge.
